// File: rtl/l0_seq.sv
// l0_seq: streams row-vectors from SRAM into the L0 FIFOs and drains them into the MAC array.
// Optional feature macro L0_SKEW_EN: per-row read enables form a diagonal wavefront.
module l0_seq #(
  parameter int row    = 8,
  parameter int depth  = 64,
  parameter int addr_w = 11,
  parameter int len_w  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [len_w-1:0]  len,
  input  logic              drain_ready,
  input  logic              l0_full,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic [row-1:0]    l0_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int dw = $clog2(depth + 1);
  localparam int cw = ((len_w > dw) ? len_w : dw) + 1;
  localparam int fw = $clog2(row + 1);
`ifdef L0_SKEW_EN
  localparam int flush_len = row;
`else
  localparam int flush_len = 1;
`endif
  localparam logic [cw-1:0] dep    = cw'(depth);
  localparam logic [fw-1:0] fl_end = fw'(flush_len - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [addr_w-1:0] base_q, addr_q;
  logic [cw-1:0]     len_q, iss_q, wcnt_q, rcnt_q;
  logic [fw-1:0]     fl_q;
  logic              cen_q, wr_q, err_q;
  logic              accept, issue, rd_dec, running;

  // occ + inflight is issued - read decisions; avail is written - read decisions
  assign running = (state_q == RUN);
  assign accept  = (state_q == IDLE) && start;
  assign issue   = running && (iss_q < len_q)
                && ((iss_q - rcnt_q) < dep);
  assign rd_dec  = running && drain_ready
                && (wcnt_q != rcnt_q) && (rcnt_q < len_q);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (rcnt_q == len_q) state_d = FLUSH;
      end
      FLUSH: begin
        if (fl_q == fl_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // transfer parameters and progress counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      len_q  <= '0;
      iss_q  <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      fl_q   <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        len_q  <= cw'(len);
        iss_q  <= '0;
        wcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        if (issue)  iss_q  <= iss_q + 1'b1;
        if (wr_q)   wcnt_q <= wcnt_q + 1'b1;
        if (rd_dec) rcnt_q <= rcnt_q + 1'b1;
      end
      fl_q <= (state_q == FLUSH) ? fl_q + 1'b1 : '0;
    end
  end

  // SRAM request, 1-cycle-later L0 write strobe, sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cen_q  <= 1'b1;
      addr_q <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cen_q <= ~issue;
      if (issue) addr_q <= base_q + addr_w'(iss_q);
      wr_q <= ~cen_q;
      if (accept)              err_q <= 1'b0;
      else if (l0_full && wr_q) err_q <= 1'b1;
    end
  end

`ifdef L0_SKEW_EN
  logic [row-1:0] rd_q;

  // row i fires one cycle after row i-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_q <= '0;
    else        rd_q <= (rd_q << 1) | row'(rd_dec);
  end

  assign l0_rd = rd_q;
`else
  logic rd_q;

  // all rows read together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_q <= 1'b0;
    else        rd_q <= rd_dec;
  end

  assign l0_rd = {row{rd_q}};
`endif

  assign sram_cen  = cen_q;
  assign sram_wen  = 1'b1;
  assign sram_addr = addr_q;
  assign l0_wr     = wr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_l0_seq.sv
// tb_l0_seq: directed and randomized transfers for l0_seq
// against a counting reference model of the load/drain rules.
module tb_l0_seq;

  localparam int row    = 8;
  localparam int depth  = 64;
  localparam int addr_w = 11;
  localparam int len_w  = 7;
`ifdef L0_SKEW_EN
  localparam int gap_min = row;
`else
  localparam int gap_min = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [addr_w-1:0] base_addr = '0;
  logic [len_w-1:0]  len = '0;
  logic              drain_ready = 1'b0;
  logic              l0_full = 1'b0;
  logic              sram_cen, sram_wen, l0_wr;
  logic [addr_w-1:0] sram_addr;
  logic [row-1:0]    l0_rd;
  logic              busy, done, err;

  l0_seq #(
    .row(row), .depth(depth), .addr_w(addr_w), .len_w(len_w)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .len(len),
    .drain_ready(drain_ready), .l0_full(l0_full),
    .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_base, m_len;
  int n_cen, n_wr, n_wr_lag, n_rd;
  int cyc, last_rd, done_cnt;
  logic p_busy, p_cen, p_wr, p_done;
  logic err_exp, busy_exp;
  logic [row-1:0] rd_hist;

  int obs_cen, obs_wr, obs_rd, cen_first, cen_last;
  int addr_log[$];
  int rd_log[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_base = 0; m_len = 0;
    n_cen = 0; n_wr = 0; n_wr_lag = 0; n_rd = 0;
    p_busy = 0; p_cen = 0; p_wr = 0; p_done = 0;
    err_exp = 0; busy_exp = 0; rd_hist = '0;
    last_rd = 0; done_cnt = 0;
  endtask

  task automatic obs_clear();
    obs_cen = 0; obs_wr = 0; obs_rd = 0;
    cen_first = -1; cen_last = -1;
    addr_log.delete();
    rd_log.delete();
  endtask

  // One clock: predict from the inputs of the cycle
  // just ending, then sample and compare at negedge.
  task automatic tick();
    logic acc, dr, full, ec, er, ew;
    logic [row-1:0] ev;
    dr = drain_ready;
    full = l0_full;
    acc = start && !p_busy;
    if (acc) begin
      m_base = int'(base_addr);
      m_len = int'(len);
      n_cen = 0; n_wr = 0; n_wr_lag = 0; n_rd = 0;
      done_cnt = 0;
      obs_clear();
    end
    ec = p_busy && (n_cen < m_len)
      && ((n_cen - n_rd) < depth);
    er = p_busy && dr && (n_wr_lag > n_rd)
      && (n_rd < m_len);
    ew = p_cen;
    if (acc) err_exp = 1'b0;
    else if (full && p_wr) err_exp = 1'b1;
    if (acc) busy_exp = 1'b1;
    else if (p_done) busy_exp = 1'b0;
    rd_hist = {rd_hist[row-2:0], er};
`ifdef L0_SKEW_EN
    ev = rd_hist;
`else
    ev = {row{er}};
`endif
    @(negedge clk);
    cyc++;
    check("sram_wen", 32'(sram_wen), 32'(1'b1));
    check("busy", 32'(busy), 32'(busy_exp));
    check("err", 32'(err), 32'(err_exp));
    check("sram_cen", 32'(sram_cen), 32'(!ec));
    if (ec)
      check("sram_addr", 32'(sram_addr),
            32'((m_base + n_cen) % (1 << addr_w)));
    check("l0_wr", 32'(l0_wr), 32'(ew));
    check("l0_rd", 32'(l0_rd), 32'(ev));
    if (!sram_cen) begin
      obs_cen++;
      addr_log.push_back(int'(sram_addr));
      if (cen_first < 0) cen_first = cyc;
      cen_last = cyc;
    end
    if (l0_wr) obs_wr++;
    if (l0_rd[0]) obs_rd++;
    if (l0_rd != '0) rd_log.push_back(int'(l0_rd));
    check("occupancy", 32'((obs_wr - obs_rd) <= depth),
          32'(1'b1));
    if (ec) n_cen++;
    n_wr_lag = n_wr;
    if (ew) n_wr++;
    if (er) begin
      n_rd++;
      last_rd = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_all_read", 32'(obs_rd), 32'(m_len));
      check("done_width", 32'(p_done), 32'(1'b0));
      if (m_len > 0)
        check("done_after_flush",
              32'((cyc - last_rd) >= gap_min), 32'(1'b1));
    end
    p_busy = busy_exp;
    p_cen = ec;
    p_wr = ew;
    p_done = done;
  endtask

  // mode 0: drain always ready; mode 1: random drain
  // and stray start pulses that must be ignored
  task automatic run_xfer(input int b, input int n,
                          input int mode, input int budget);
    int k;
    base_addr = addr_w'(b);
    len = len_w'(n);
    start = 1'b1;
    drain_ready = (mode == 0) ? 1'b1
                : 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < budget) begin
      if (mode == 0) begin
        drain_ready = 1'b1;
      end else begin
        drain_ready = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 15) == 0);
        base_addr = addr_w'($urandom_range(0, 2047));
        len = len_w'($urandom_range(0, 127));
      end
      tick();
      start = 1'b0;
      k++;
    end
    check("done_seen", 32'(done), 32'(1'b1));
    tick();
    tick();
    check("done_count", 32'(done_cnt), 32'(1));
    check("busy_idle", 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int k, b, n;
    cyc = 0;
    model_clear();
    obs_clear();

    repeat (2) @(negedge clk);
    check("rst_cen", 32'(sram_cen), 32'(1'b1));
    check("rst_wen", 32'(sram_wen), 32'(1'b1));
    check("rst_addr", 32'(sram_addr), 32'(0));
    check("rst_wr", 32'(l0_wr), 32'(1'b0));
    check("rst_rd", 32'(l0_rd), 32'(0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_err", 32'(err), 32'(1'b0));
    reset = 1'b1;
    tick();
    tick();

    // basic transfer
    run_xfer('h010, 4, 0, 200);
    check("t1_cen_cnt", 32'(obs_cen), 32'(4));
    check("t1_cen_run", 32'(cen_last - cen_first), 32'(3));
    check("t1_wr_cnt", 32'(obs_wr), 32'(4));
    check("t1_rd_cnt", 32'(obs_rd), 32'(4));
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++)
        check("t1_addr", 32'(addr_log[i]), 32'('h010 + i));

    // back-pressure: loads stop at FIFO depth
    base_addr = addr_w'($urandom_range(0, 2047));
    len = len_w'(100);
    start = 1'b1;
    drain_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (79) tick();
    check("stall_issues", 32'(obs_cen), 32'(depth));
    check("stall_err", 32'(err), 32'(1'b0));
    drain_ready = 1'b1;
    k = 0;
    while (!done && k < 1000) begin
      tick();
      k++;
    end
    check("stall_done", 32'(done), 32'(1'b1));
    check("stall_rd_cnt", 32'(obs_rd), 32'(100));
    tick();
    tick();

    // single vector: read-enable wavefront
    run_xfer($urandom_range(0, 2047), 1, 0, 200);
`ifdef L0_SKEW_EN
    check("w_len", 32'(rd_log.size()), 32'(row));
    if (rd_log.size() == row)
      for (int i = 0; i < row; i++)
        check("w_onehot", 32'(rd_log[i]), 32'(1 << i));
`else
    check("w_len", 32'(rd_log.size()), 32'(1));
    if (rd_log.size() == 1)
      check("w_all", 32'(rd_log[0]), 32'((1 << row) - 1));
`endif

    // zero-length transfer
    base_addr = addr_w'('h123);
    len = '0;
    start = 1'b1;
    tick();
    check("len0_done", 32'(done), 32'(1'b1));
    start = 1'b0;
    tick();
    tick();
    check("len0_cen", 32'(obs_cen), 32'(0));
    check("len0_wr", 32'(obs_wr), 32'(0));

    // asynchronous reset mid-transfer
    base_addr = addr_w'($urandom_range(0, 2047));
    len = len_w'(100);
    start = 1'b1;
    drain_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (obs_cen < 10 && k < 50) begin
      tick();
      k++;
    end
    check("ar_reach", 32'(obs_cen), 32'(10));
    #2 reset = 1'b0;
    #1;
    check("ar_cen", 32'(sram_cen), 32'(1'b1));
    check("ar_wen", 32'(sram_wen), 32'(1'b1));
    check("ar_addr", 32'(sram_addr), 32'(0));
    check("ar_wr", 32'(l0_wr), 32'(1'b0));
    check("ar_rd", 32'(l0_rd), 32'(0));
    check("ar_busy", 32'(busy), 32'(1'b0));
    check("ar_done", 32'(done), 32'(1'b0));
    check("ar_err", 32'(err), 32'(1'b0));
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_xfer($urandom_range(0, 2047), 3, 0, 200);
    check("ar_after_rd", 32'(obs_rd), 32'(3));

    // address wrap
    run_xfer('h7FE, 4, 0, 200);
    check("wrap_cnt", 32'(addr_log.size()), 32'(4));
    if (addr_log.size() == 4) begin
      check("wrap_a0", 32'(addr_log[0]), 32'('h7FE));
      check("wrap_a1", 32'(addr_log[1]), 32'('h7FF));
      check("wrap_a2", 32'(addr_log[2]), 32'('h000));
      check("wrap_a3", 32'(addr_log[3]), 32'('h001));
    end

    // l0_full during a write sets sticky err
    base_addr = addr_w'($urandom_range(0, 2047));
    len = len_w'(8);
    start = 1'b1;
    drain_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!p_wr && k < 20) begin
      tick();
      k++;
    end
    check("ef_wr_seen", 32'(l0_wr), 32'(1'b1));
    l0_full = 1'b1;
    tick();
    l0_full = 1'b0;
    check("ef_set", 32'(err), 32'(1'b1));
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("ef_sticky", 32'(err), 32'(1'b1));
    run_xfer($urandom_range(0, 2047), 2, 0, 200);
    check("ef_cleared", 32'(err), 32'(1'b0));

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, 2047);
      n = ($urandom_range(0, 7) == 0) ? 0
        : $urandom_range(1, 127);
      run_xfer(b, n, 1, 3000);
      check("rnd_cen_cnt", 32'(obs_cen), 32'(n));
      check("rnd_rd_cnt", 32'(obs_rd), 32'(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
